// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag serial transmitter: master-reset sequence plus LSB-first packet shifter.
// Optional post-packet idle gap enabled by defining BSG_TAG_TX_IDLE_GAP_EN.
module bsg_tag_serial_tx #(
  parameter int els_p       = 32,
  parameter int lg_width_p  = 4,
  parameter int reset_len_p = 64,
  parameter int idle_gap_p  = 4,
  localparam int lg_els_lp  = $clog2(els_p),
  localparam int width_lp   = (1 << lg_width_p) - 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  master_reset_v_i,
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic [lg_els_lp-1:0]  node_id_i,
  input  logic                  data_not_reset_i,
  input  logic [lg_width_p-1:0] len_i,
  input  logic [width_lp-1:0]   payload_i,
  output logic                  tag_data_o,
  output logic                  tag_en_o,
  output logic                  busy_o
);

  localparam int sr_w_lp    = lg_els_lp + 1 + lg_width_p + width_lp;
  localparam int hdr_lp     = 1 + lg_els_lp + lg_width_p;
  localparam int pkt_max_lp = 2 + lg_els_lp + lg_width_p + width_lp;
  localparam int big_lp     = (reset_len_p > pkt_max_lp) ? reset_len_p : pkt_max_lp;
  localparam int max_cnt_lp = (idle_gap_p > big_lp) ? idle_gap_p : big_lp;
  localparam int cnt_w_lp   = $clog2(max_cnt_lp + 1);
  // The IDLE cycle that follows GAP is the last zero cycle of the gap
  localparam int gap_ld_lp  = (idle_gap_p > 2) ? idle_gap_p - 2 : 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MRST  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_end_state;
  logic [sr_w_lp-1:0]  r_sr;
  logic [cnt_w_lp-1:0] r_cnt;
  logic [cnt_w_lp-1:0] w_pkt_cnt;
  logic                r_data;
  logic                r_en;

  assign ready_o    = (r_state == ST_IDLE) & ~master_reset_v_i;
  assign busy_o     = (r_state != ST_IDLE);
  assign tag_data_o = r_data;
  assign tag_en_o   = r_en;
  assign w_pkt_cnt  = cnt_w_lp'(hdr_lp) + cnt_w_lp'(len_i);

  always_comb begin
    w_end_state = ST_IDLE;
`ifdef BSG_TAG_TX_IDLE_GAP_EN
    if (idle_gap_p > 1) w_end_state = ST_GAP;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_data  <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (master_reset_v_i) begin
            r_state <= ST_MRST;
            r_cnt   <= cnt_w_lp'(reset_len_p - 1);
            r_data  <= 1'b1;
            r_en    <= 1'b1;
          end else if (v_i) begin
            r_state <= ST_SHIFT;
            r_sr    <= {payload_i, len_i, data_not_reset_i, node_id_i};
            r_cnt   <= w_pkt_cnt;
            r_data  <= 1'b1;
            r_en    <= 1'b1;
          end else begin
            r_data  <= 1'b0;
            r_en    <= 1'b0;
          end
        end
        ST_MRST: begin
          if (r_cnt == '0) begin
            r_state <= w_end_state;
            r_cnt   <= cnt_w_lp'(gap_ld_lp);
            r_data  <= 1'b0;
            r_en    <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_cnt == '0) begin
            r_state <= w_end_state;
            r_cnt   <= cnt_w_lp'(gap_ld_lp);
            r_data  <= 1'b0;
            r_en    <= 1'b0;
          end else begin
            r_data  <= r_sr[0];
            r_sr    <= r_sr >> 1;
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// Directed bench for bsg_tag_serial_tx (els_p=32, lg_width_p=4, reset_len_p=64).
// Zero-cycle expectations follow BSG_TAG_TX_IDLE_GAP_EN when defined.
module tb_bsg_tag_serial_tx;

`ifdef BSG_TAG_TX_IDLE_GAP_EN
  localparam bit GAP_ON = 1'b1;
  localparam int GAP_Z  = 4;
`else
  localparam bit GAP_ON = 1'b0;
  localparam int GAP_Z  = 1;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        master_reset_v_i = 1'b0;
  logic        v_i = 1'b0;
  logic        ready_o;
  logic [4:0]  node_id_i = '0;
  logic        data_not_reset_i = 1'b0;
  logic [3:0]  len_i = '0;
  logic [14:0] payload_i = '0;
  logic        tag_data_o;
  logic        tag_en_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  bsg_tag_serial_tx #(
    .els_p(32), .lg_width_p(4), .reset_len_p(64), .idle_gap_p(4)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .master_reset_v_i(master_reset_v_i),
    .v_i(v_i),
    .ready_o(ready_o),
    .node_id_i(node_id_i),
    .data_not_reset_i(data_not_reset_i),
    .len_i(len_i),
    .payload_i(payload_i),
    .tag_data_o(tag_data_o),
    .tag_en_o(tag_en_o),
    .busy_o(busy_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    tick();
    tick();
    checks++;
    if (tag_data_o !== 1'b0) begin
      errors++; $display("FAIL reset_data got=%b exp=0", tag_data_o);
    end
    checks++;
    if (tag_en_o !== 1'b0) begin
      errors++; $display("FAIL reset_en got=%b exp=0", tag_en_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", busy_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", ready_o);
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_master_reset;
    int n;
    master_reset_v_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL mrst_ready got=%b exp=0", ready_o);
    end
    tick();
    master_reset_v_i = 1'b0;
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (tag_data_o !== 1'b1 || tag_en_o !== 1'b1 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL mrst_cyc%0d got d=%b e=%b b=%b exp 1,1,1",
                 k, tag_data_o, tag_en_o, busy_o);
      end
      tick();
    end
    checks++;
    if (tag_data_o !== 1'b0 || tag_en_o !== 1'b0 || busy_o !== GAP_ON) begin
      errors++;
      $display("FAIL mrst_end got d=%b e=%b b=%b exp 0,0,%b",
               tag_data_o, tag_en_o, busy_o, GAP_ON);
    end
    n = 0;
    while (busy_o && n < 20) begin
      tick(); n++;
    end
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mrst_idle got b=%b r=%b exp 0,1", busy_o, ready_o);
    end
  endtask

  task automatic test_data_packet;
    logic [13:0] exp_bits;
    exp_bits = 14'b10100111001011;
    node_id_i = 5'd5; data_not_reset_i = 1'b1;
    len_i = 4'd3; payload_i = 15'h7ffd;
    v_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL pkt_ready got=%b exp=1", ready_o);
    end
    tick();
    v_i = 1'b0;
    node_id_i = 5'd0; len_i = 4'd15; data_not_reset_i = 1'b0;
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (tag_en_o !== 1'b1 || tag_data_o !== exp_bits[i]) begin
        errors++;
        $display("FAIL pkt_bit%0d got d=%b e=%b exp d=%b e=1",
                 i, tag_data_o, tag_en_o, exp_bits[i]);
      end
      tick();
    end
    checks++;
    if (tag_en_o !== 1'b0 || tag_data_o !== 1'b0 ||
        busy_o !== GAP_ON) begin
      errors++;
      $display("FAIL pkt_end got d=%b e=%b b=%b exp 0,0,%b",
               tag_data_o, tag_en_o, busy_o, GAP_ON);
    end
    for (int i = 0; i < 5 && busy_o; i++) tick();
  endtask

  task automatic test_len0;
    logic [10:0] exp_bits;
    exp_bits = 11'b00000111111;
    node_id_i = 5'd31; data_not_reset_i = 1'b0;
    len_i = 4'd0; payload_i = 15'h7fff;
    v_i = 1'b1;
    tick();
    v_i = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (tag_en_o !== 1'b1 || tag_data_o !== exp_bits[i]) begin
        errors++;
        $display("FAIL len0_bit%0d got d=%b e=%b exp d=%b e=1",
                 i, tag_data_o, tag_en_o, exp_bits[i]);
      end
      tick();
    end
    checks++;
    if (tag_en_o !== 1'b0 || ready_o !== !GAP_ON) begin
      errors++;
      $display("FAIL len0_end got e=%b r=%b exp 0,%b",
               tag_en_o, ready_o, !GAP_ON);
    end
    for (int i = 0; i < 5 && busy_o; i++) tick();
  endtask

  task automatic test_simultaneous;
    int n;
    node_id_i = 5'd5; data_not_reset_i = 1'b1;
    len_i = 4'd3; payload_i = 15'h0005;
    master_reset_v_i = 1'b1;
    v_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL sim_ready got=%b exp=0", ready_o);
    end
    tick();
    master_reset_v_i = 1'b0;
    n = 0;
    while (tag_en_o && n < 100) begin
      tick(); n++;
    end
    checks++;
    if (n !== 64) begin
      errors++; $display("FAIL sim_mrst_len got=%0d exp=64", n);
    end
    n = 0;
    while (!ready_o && n < 20) begin
      tick(); n++;
    end
    tick();
    v_i = 1'b0;
    checks++;
    if (tag_en_o !== 1'b1 || tag_data_o !== 1'b1) begin
      errors++;
      $display("FAIL sim_start got d=%b e=%b exp 1,1", tag_data_o, tag_en_o);
    end
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (tag_en_o !== 1'b0) begin
      errors++; $display("FAIL sim_end got e=%b exp 0", tag_en_o);
    end
    for (int i = 0; i < 5 && busy_o; i++) tick();
  endtask

  task automatic test_reset_mid;
    node_id_i = 5'd5; data_not_reset_i = 1'b1;
    len_i = 4'd15; payload_i = 15'h5555;
    v_i = 1'b1;
    tick();
    v_i = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    checks++;
    if (busy_o !== 1'b1 || tag_en_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got b=%b e=%b exp 1,1", busy_o, tag_en_o);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++;
    if (tag_en_o !== 1'b0 || tag_data_o !== 1'b0 ||
        busy_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got d=%b e=%b b=%b r=%b exp 0,0,0,1",
               tag_data_o, tag_en_o, busy_o, ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tag_en_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_after%0d got e=%b b=%b exp 0,0",
                 i, tag_en_o, busy_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    int z;
    node_id_i = 5'd31; data_not_reset_i = 1'b0;
    len_i = 4'd0; payload_i = 15'h0;
    v_i = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) tick();
    z = 0;
    while (!tag_en_o && z < 20) begin
      checks++;
      if (tag_data_o !== 1'b0) begin
        errors++; $display("FAIL b2b_gapdata got=%b exp=0", tag_data_o);
      end
      tick(); z++;
    end
    v_i = 1'b0;
    checks++;
    if (z !== GAP_Z) begin
      errors++; $display("FAIL b2b_gap got=%0d exp=%0d", z, GAP_Z);
    end
    checks++;
    if (tag_data_o !== 1'b1 || tag_en_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start got d=%b e=%b exp 1,1", tag_data_o, tag_en_o);
    end
    for (int i = 0; i < 11; i++) tick();
    checks++;
    if (tag_en_o !== 1'b0) begin
      errors++; $display("FAIL b2b_end got e=%b exp 0", tag_en_o);
    end
    for (int i = 0; i < 5 && busy_o; i++) tick();
  endtask

  initial begin
    test_reset();
    test_master_reset();
    test_data_packet();
    test_len0();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
